// File: rtl/rsa_cmd_ctrl.sv
// Command/data controller between the ARM mailbox and the Montgomery exponentiation core.
// Decodes READ/COMPUTE/WRITE, moves operands over valid/ready and reports completion via done/done_read.
module rsa_cmd_ctrl #(
  parameter int unsigned DATA_W         = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              arm_to_fpga_done,
  input  logic              arm_to_fpga_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic              core_start,
  output logic [DATA_W-1:0] core_operand,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [3:0]        leds
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
  // valid/ready here are decoded purely from state, so they drop the cycle after a transfer.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TX    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] in_reg_q, in_reg_d;
  logic [DATA_W-1:0] out_reg_q, out_reg_d;
  logic              err_q, err_d;
  logic [31:0]       timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      in_reg_q  <= '0;
      out_reg_q <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_reg_q  <= in_reg_d;
      out_reg_q <= out_reg_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_reg_d  = in_reg_q;
    out_reg_d = out_reg_q;
    err_d     = err_q;
    timer_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          err_d = 1'b0;
          case (arm_to_fpga_cmd)
            32'd0:   state_d = ST_RX;
            32'd1:   state_d = ST_START;
            32'd2:   state_d = ST_TX;
            default: begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_RX: begin
        if (arm_to_fpga_data_valid) begin
          in_reg_d = arm_to_fpga_data;
          state_d  = ST_DONE;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          out_reg_d = core_result;
          state_d   = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST)) begin
          // Abort keeps the previous result; err flags the failed COMPUTE.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_TX: begin
        if (fpga_to_arm_data_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (arm_to_fpga_done_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arm_to_fpga_data_ready = (state_q == ST_RX);
  assign core_start             = (state_q == ST_START);
  assign fpga_to_arm_data_valid = (state_q == ST_TX);
  assign arm_to_fpga_done       = (state_q == ST_DONE);
  assign core_operand           = in_reg_q;
  assign fpga_to_arm_data       = out_reg_q;
  assign leds                   = {err_q, state_q};

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Directed bench for rsa_cmd_ctrl: READ/COMPUTE/WRITE flows, illegal command, timeout,
// ignored inputs and reset in the middle of a transfer.
module tb_rsa_cmd_ctrl;

  localparam int DATA_W = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       cmd;
  logic              cmd_valid;
  logic              done;
  logic              done_read;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              core_start;
  logic [DATA_W-1:0] core_operand;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic [3:0]        leds;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  rsa_cmd_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(100)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .arm_to_fpga_cmd        (cmd),
    .arm_to_fpga_cmd_valid  (cmd_valid),
    .arm_to_fpga_done       (done),
    .arm_to_fpga_done_read  (done_read),
    .arm_to_fpga_data_valid (in_valid),
    .arm_to_fpga_data_ready (in_ready),
    .arm_to_fpga_data       (in_data),
    .fpga_to_arm_data_valid (out_valid),
    .fpga_to_arm_data_ready (out_ready),
    .fpga_to_arm_data       (out_data),
    .core_start             (core_start),
    .core_operand           (core_operand),
    .core_done              (core_done),
    .core_result            (core_result),
    .leds                   (leds)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp_v);
    int w;
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      w = 0;
      for (int i = DATA_W/64 - 1; i >= 0; i--)
        if (obs[i*64 +: 64] !== exp_v[i*64 +: 64]) w = i;
      $error("FAIL %s word%0d observed=%0h expected=%0h", tag, w,
             obs[w*64 +: 64], exp_v[w*64 +: 64]);
    end
  endtask

  // Driver tasks
  task automatic send_cmd(input logic [31:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd       = 32'hffff_ffff;
  endtask

  task automatic ack_done(input string tag);
    chk({tag, "_done_hi"}, 32'(done), 32'd1);
    done_read = 1'b1;
    step();
    done_read = 1'b0;
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  task automatic do_read(input logic [DATA_W-1:0] d);
    send_cmd(32'd0);
    chk("rd_ready", 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    chk("rd_ready_drop", 32'(in_ready), 32'd0);
    chk("rd_done", 32'(done), 32'd1);
    chk_wide("rd_operand", core_operand, d);
    ack_done("rd");
  endtask

  task automatic do_write();
    logic [DATA_W-1:0] e;
    send_cmd(32'd2);
    chk("wr_valid", 32'(out_valid), 32'd1);
    chk("wr_leds", 32'(leds[2:0]), 32'd4);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL wr_scoreboard observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk_wide("wr_data", out_data, e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wr_valid_drop", 32'(out_valid), 32'd0);
    ack_done("wr");
  endtask

  initial begin : stim
    logic [DATA_W-1:0] d1;
    int starts;
    int n;

    reset = 1'b1; cmd = '0; cmd_valid = 1'b0; done_read = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    core_done = 1'b0; core_result = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk_wide("rst_out", out_data, '0);

    // READ then WRITE without COMPUTE
    d1 = '0;
    d1[895:832] = 64'h0123_4567_89ab_cdef;
    d1[31:0]    = 32'h1357_9bdf;
    do_read(d1);
    exp_q.push_back('0);
    do_write();

    // Full flow: READ 5, COMPUTE (core answers 0x19 after 40 cycles), WRITE
    do_read(1024'h5);
    send_cmd(32'd1);
    chk("cmp_start", 32'(core_start), 32'd1);
    chk("cmp_leds_start", 32'(leds), 32'd2);
    chk_wide("cmp_operand", core_operand, 1024'h5);
    starts = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (core_start) starts++;
      if (i == 20) chk("cmp_leds_wait", 32'(leds), 32'd3);
    end
    core_done   = 1'b1;
    core_result = 1024'h19;
    step();
    core_done   = 1'b0;
    core_result = '0;
    chk("cmp_extra_starts", 32'(starts), 32'd0);
    chk("cmp_leds_done", 32'(leds), 32'd5);
    ack_done("cmp");
    exp_q.push_back(1024'h19);
    do_write();

    // Illegal command
    send_cmd(32'h7);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_leds", 32'(leds), 32'hd);
    chk("ill_ready", 32'(in_ready), 32'd0);
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_start", 32'(core_start), 32'd0);
    ack_done("ill");
    chk("ill_err_kept", 32'(leds), 32'h8);
    send_cmd(32'd0);
    chk("ill_err_clr", 32'(leds), 32'h1);
    in_data = 1024'hab; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ack_done("ill_rd");

    // Timeout: core never answers
    send_cmd(32'd1);
    chk("to_start", 32'(core_start), 32'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (leds[2:0] != 3'd3) break;
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd100);
    chk("to_leds", 32'(leds), 32'hd);
    chk_wide("to_out_kept", out_data, 1024'h19);
    ack_done("to");

    // Ignored inputs
    core_done = 1'b1; core_result = 1024'hdead;
    step();
    core_done = 1'b0; core_result = '0;
    chk("ign_core_idle_leds", 32'(leds), 32'h8);
    chk("ign_core_idle_done", 32'(done), 32'd0);
    send_cmd(32'd0);
    send_cmd(32'd2);
    chk("ign_cmd_rx", 32'(leds), 32'h1);
    in_data = 1024'h42; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    send_cmd(32'd1);
    chk("ign_cmd_done", 32'(leds), 32'h5);
    ack_done("ign_rd");
    send_cmd(32'd1);
    step();
    send_cmd(32'd0);
    chk("ign_cmd_wait", 32'(leds), 32'h3);
    core_done = 1'b1; core_result = 1024'h77;
    step();
    core_done = 1'b0; core_result = '0;
    ack_done("ign_cmp");
    step();
    chk("ign_no_extra_done", 32'(done), 32'd0);
    exp_q.push_back(1024'h77);
    do_write();

    // Reset while stalled in TX
    send_cmd(32'd2);
    step(); step();
    chk("rst_tx_valid_held", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_tx_leds", 32'(leds), 32'd0);
    chk("rst_tx_valid", 32'(out_valid), 32'd0);
    chk("rst_tx_done", 32'(done), 32'd0);
    chk("rst_tx_start", 32'(core_start), 32'd0);
    chk_wide("rst_tx_out", out_data, '0);
    chk_wide("rst_tx_operand", core_operand, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
